strided_input_write_addr_gen: RTL

Parametrised successor to the flat input-bank write address counter. Walks a block as three nested counters (IX0 innermost, then IY0, then IC1) and adds a configurable row pitch, so blocks can land in a bank with padded rows. Toggles a double-buffer bank select at every block boundary. Sits between the top-level input loader and the input double-buffer write port.

---
 rtl/strided_input_write_addr_gen_pkg.sv | 21 ++
 rtl/strided_input_write_addr_gen_wrap_counter.sv | 31 +++
 rtl/strided_input_write_addr_gen.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/strided_input_write_addr_gen_pkg.sv
// Shared definitions for the strided input-bank write address generator:
// FSM states and the order in which configuration words are taken.
package strided_input_write_addr_gen_pkg;

   typedef enum logic [1:0] {
      UNCFG   = 2'd0,
      LOADING = 2'd1,
      READY   = 2'd2
   } state_t;

   // Index of a configuration word within the load sequence.
   typedef logic [1:0] cfg_idx_t;

   localparam cfg_idx_t CFG_IX0   = 2'd0;
   localparam cfg_idx_t CFG_IY0   = 2'd1;
   localparam cfg_idx_t CFG_IC1   = 2'd2;
   localparam cfg_idx_t CFG_PITCH = 2'd3;

   localparam int CFG_WORDS = 4;

endpackage

// File: rtl/strided_input_write_addr_gen_wrap_counter.sv
// Wrapping counter 0 .. limit-1. Chained stages ripple their enables so the
// next stage only advances when this one wraps.
module wrap_counter #(
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   en,
   input  logic [COUNT_WIDTH-1:0] limit,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   at_last
);

   // Stored limits are never 0 once configured, so limit-1 is the final count.
   assign at_last = (count == (limit - COUNT_WIDTH'(1)));

   // Count register: clear wins over enable, wrap to 0 after the last value.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= at_last ? '0 : count + COUNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/strided_input_write_addr_gen.sv
// Input-bank write address generator: walks IX0 x IY0 x IC1 positions with a
// configurable row pitch and toggles the double-buffer bank at each block end.
module strided_input_write_addr_gen
   import strided_input_write_addr_gen_pkg::*;
#(
   parameter int CONFIG_WIDTH    = 32,
   parameter int BANK_ADDR_WIDTH = 32,
   parameter int COUNT_WIDTH     = 16,
   parameter int NUM_BANKS       = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         config_enable,
   input  logic [CONFIG_WIDTH-1:0]      config_data,
   input  logic                         addr_enable,
   output logic [BANK_ADDR_WIDTH-1:0]   addr,
   output logic [$clog2(NUM_BANKS)-1:0] bank_sel,
   output logic                         config_valid,
   output logic                         writing_last_data,
   output logic                         block_done
);

   localparam int BANK_SEL_WIDTH = $clog2(NUM_BANKS);
   localparam logic [BANK_SEL_WIDTH-1:0] LAST_BANK = BANK_SEL_WIDTH'(NUM_BANKS - 1);

   state_t                     state;
   cfg_idx_t                   word_idx;
   cfg_idx_t                   cfg_idx;
   logic [COUNT_WIDTH-1:0]     ix0_limit;
   logic [COUNT_WIDTH-1:0]     iy0_limit;
   logic [COUNT_WIDTH-1:0]     ic1_limit;
   logic [BANK_ADDR_WIDTH-1:0] row_pitch;
   logic [BANK_ADDR_WIDTH-1:0] row_base;
   logic [COUNT_WIDTH-1:0]     cfg_count;
   logic [COUNT_WIDTH-1:0]     cfg_limit;
   logic [BANK_ADDR_WIDTH-1:0] cfg_pitch;

   logic [COUNT_WIDTH-1:0] ix0;
   logic [COUNT_WIDTH-1:0] iy0;
   logic [COUNT_WIDTH-1:0] ic1;
   logic                   ix0_last;
   logic                   iy0_last;
   logic                   ic1_last;
   logic                   step;
   logic                   iy0_en;
   logic                   ic1_en;
   logic                   block_last;
   logic                   unused_counts;

   // A word arriving outside LOADING always restarts the sequence at IX0.
   assign cfg_idx   = (state == LOADING) ? word_idx : CFG_IX0;
   assign cfg_count = COUNT_WIDTH'(config_data);
   assign cfg_limit = (cfg_count == '0) ? COUNT_WIDTH'(1) : cfg_count;
   assign cfg_pitch = BANK_ADDR_WIDTH'(config_data);

   // Configuration takes priority over a simultaneous step request.
   assign step       = addr_enable && (state == READY) && !config_enable;
   assign iy0_en     = step && ix0_last;
   assign ic1_en     = iy0_en && iy0_last;
   assign block_last = ix0_last && iy0_last && ic1_last;

   wrap_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_ix0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (config_enable),
      .en      (step),
      .limit   (ix0_limit),
      .count   (ix0),
      .at_last (ix0_last)
   );

   wrap_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_iy0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (config_enable),
      .en      (iy0_en),
      .limit   (iy0_limit),
      .count   (iy0),
      .at_last (iy0_last)
   );

   wrap_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_ic1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (config_enable),
      .en      (ic1_en),
      .limit   (ic1_limit),
      .count   (ic1),
      .at_last (ic1_last)
   );

   // Row and plane indices only matter through their wrap flags; row_base
   // already carries the row offset into the address.
   assign unused_counts = ^{iy0, ic1};

   assign addr              = row_base + BANK_ADDR_WIDTH'(ix0);
   assign writing_last_data = addr_enable && config_valid && block_last;

   // Configuration FSM: stores words in order and flags a complete set.
   // NOTE: the four config words are a handful of flops, not a RAM, so they
   // are reset to keep the post-reset state fully defined.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= UNCFG;
         word_idx     <= CFG_IX0;
         ix0_limit    <= '0;
         iy0_limit    <= '0;
         ic1_limit    <= '0;
         row_pitch    <= '0;
         config_valid <= 1'b0;
      end else if (config_enable) begin
         case (cfg_idx)
            CFG_IX0: ix0_limit <= cfg_limit;
            CFG_IY0: iy0_limit <= cfg_limit;
            CFG_IC1: ic1_limit <= cfg_limit;
            default: row_pitch <= cfg_pitch;
         endcase
         config_valid <= (cfg_idx == CFG_PITCH);
         if (cfg_idx == CFG_PITCH) begin
            state    <= READY;
            word_idx <= CFG_IX0;
         end else begin
            state    <= LOADING;
            word_idx <= cfg_idx + 2'd1;
         end
      end
   end

   // Row base accumulation, bank rotation and the end-of-block pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_base   <= '0;
         bank_sel   <= '0;
         block_done <= 1'b0;
      end else begin
         block_done <= step && block_last;
         if (config_enable) begin
            row_base <= '0;
         end else if (step) begin
            if (block_last) begin
               row_base <= '0;
               bank_sel <= (bank_sel == LAST_BANK) ? '0 : bank_sel + BANK_SEL_WIDTH'(1);
            end else if (ix0_last) begin
               row_base <= row_base + row_pitch;
            end
         end
      end
   end

endmodule
